// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file writeback path
//
// Purpose: default geometry of the 32x32 register file, the arbiter FSM state
// type and the writeback request record used by regfile_wb_arbiter.
// Ports: none (package).

package regfile_pkg;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NREGS = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } wb_state_e;

  // Destination register and payload of one writeback.
  // The field is called rd because "reg" is a reserved word.
  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request and register file write bundle
//
// Purpose: groups both writeback requesters (ALU = port 0, memory = port 1)
// and the register file write port into one bundle.
// Ports (signals):
//   req0_valid/req0_reg/req0_data -> req0_ready   ALU writeback handshake
//   req1_valid/req1_reg/req1_data -> req1_ready   memory writeback handshake
//   rf_we/rf_waddr/rf_wdata                       register file write inputs
// Modports: master = requesters / register file side, slave = arbiter.

interface regfile_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);

  logic          req0_valid;
  logic [AW-1:0] req0_reg;
  logic [DW-1:0] req0_data;
  logic          req0_ready;

  logic          req1_valid;
  logic [AW-1:0] req1_reg;
  logic [DW-1:0] req1_data;
  logic          req1_ready;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready,
    output rf_we, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// rtl/regfile_wb_arbiter_rr_arb2.sv - two-way round-robin grant
//
// Purpose: combinational one-hot grant between two requests; a single pointer
// flop decides the winner when both request and flips only in that case.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (ptr -> port 0)
//   en             arbitration enabled; no grant and no pointer change when low
//   req0, req1     request inputs
//   gnt0, gnt1     grant outputs, at most one high

module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  // ptr == 0 favours port 0 on a tie, ptr == 1 favours port 1.
  logic ptr;

  assign gnt0 = en & req0 & (~req1 | ~ptr);
  assign gnt1 = en & req1 & (~req0 |  ptr);

  // Only a real tie consumes the pointer; a lone requester never skews fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (en && req0 && req1) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write port owner: init sweep then writeback arbitration
//
// Purpose: after reset, writes INIT_VALUE to registers 0..NREGS-1 (one per
// cycle), then shares the single register file write port between the ALU
// (port 0) and memory (port 1) writeback requesters with round-robin arbitration.
// Writes to register 0 are accepted but never reach the register file.
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   init_done  high from the cycle after the last sweep write until reset
//   bus        slave side of regfile_wb_arbiter_if (requests in, readies and
//              registered rf_we/rf_waddr/rf_wdata out)

module regfile_wb_arbiter #(
  parameter int            DW         = regfile_pkg::DW,
  parameter int            AW         = regfile_pkg::AW,
  parameter int            NREGS      = regfile_pkg::NREGS,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_done,
  regfile_wb_arbiter_if.slave  bus
);

  import regfile_pkg::*;

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  wb_state_e     state;
  logic [AW-1:0] cnt;
  logic          run;
  logic          gnt0;
  logic          gnt1;
  wb_req_t       sel;

  // Readies are only ever raised in RUN, so requests made during the sweep
  // simply wait at their source.
  assign run = (state == RUN);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .req0  (bus.req0_valid),
    .req1  (bus.req1_valid),
    .gnt0  (gnt0),
    .gnt1  (gnt1)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Payload of whichever port won this cycle.
  always_comb begin
    sel.rd   = bus.req0_reg;
    sel.data = bus.req0_data;
    if (gnt1) begin
      sel.rd   = bus.req1_reg;
      sel.data = bus.req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INIT;
      cnt          <= '0;
      init_done    <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      case (state)
        INIT: begin
          bus.rf_we    <= 1'b1;
          bus.rf_waddr <= cnt;
          bus.rf_wdata <= INIT_VALUE;
          if (cnt == LAST_REG) begin
            state <= RUN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // Raised one edge after the final sweep write is registered.
          init_done <= 1'b1;
          if (gnt0 || gnt1) begin
            // Register 0 is hardwired: the handshake completes, the write is dropped.
            bus.rf_we    <= (sel.rd != '0);
            bus.rf_waddr <= sel.rd;
            bus.rf_wdata <= sel.data;
          end else begin
            bus.rf_we <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

endmodule
